dual_port_sync_ram_param: RTL and testbench

Parametrised simple dual-port synchronous RAM: one write port and one read port on a single clock. Adds byte-lane write enables, write-first forwarding on same-address collisions, and a post-reset clear sequencer that fills memory with a known value. It is the general-purpose storage block for FIFOs, line buffers and register files in the sequential-circuits library.

---
 rtl/dpram_pkg.sv | 28 ++
 rtl/dpram_init_fsm.sv | 47 ++++
 rtl/dual_port_sync_ram_param.sv | 120 ++++++++++++
 tb/tb_dual_port_sync_ram_param.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared types, default sizes and the byte-lane merge helper for the dual-port RAM.
package dpram_pkg;

    typedef enum logic {CLEAR, READY} state_e;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEF_DEPTH      = 16;

    // be_merge works on the widest supported word; callers zero-extend and truncate.
    localparam int unsigned MAX_DATA_WIDTH = 1024;
    localparam int unsigned MAX_BYTES      = MAX_DATA_WIDTH / 8;

    typedef logic [MAX_DATA_WIDTH-1:0] word_max_t;
    typedef logic [MAX_BYTES-1:0]      be_max_t;

    function automatic word_max_t be_merge(input word_max_t old_word,
                                           input word_max_t new_word,
                                           input be_max_t   be);
        word_max_t res;
        res = old_word;
        for (int k = 0; k < int'(MAX_BYTES); k++) begin
            if (be[k]) res[8*k +: 8] = new_word[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dpram_init_fsm.sv
// Post-reset clear sequencer: walks every address once, then parks in READY.
module dpram_init_fsm
    import dpram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  init_busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        clr_we  = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (addr_q == LAST_ADDR) state_d = READY;
                else                     addr_d  = addr_q + 1'b1;
            end
            READY: ;
        endcase
    end

    assign init_busy = (state_q == CLEAR);
    assign clr_addr  = addr_q;

endmodule

// File: rtl/dual_port_sync_ram_param.sv
// Simple dual-port sync RAM with byte enables, write-first forwarding and a clear sequencer.
// Define DPRAM_OUT_REG_EN to add a second output register stage (read latency 2).
module dual_port_sync_ram_param
    import dpram_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned           DEPTH      = DEF_DEPTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    init_busy,
    output logic                    collision
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    typedef logic [DATA_WIDTH-1:0] data_t;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
        $error("DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (DEPTH == 0 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("DEPTH must satisfy 0 < DEPTH <= 2**ADDR_WIDTH");
    end

    data_t mem [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    dpram_init_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_init_fsm (
        .clk       (clk),
        .reset     (reset),
        .init_busy (init_busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    logic             wr_in_range, rd_in_range, wr_fire, rd_fire, hit;
    logic [IDX_W-1:0] wr_idx, rd_idx, clr_idx;
    data_t            merged_wr, rd_next;

    assign wr_idx      = wr_addr[IDX_W-1:0];
    assign rd_idx      = rd_addr[IDX_W-1:0];
    assign clr_idx     = clr_addr[IDX_W-1:0];
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

    // A write with no lanes enabled is treated as absent, so it never flags a collision.
    assign wr_fire   = !init_busy && wr_en && wr_in_range && (wr_be != '0);
    assign rd_fire   = !init_busy && rd_en;
    assign hit       = rd_fire && wr_fire && rd_in_range && (rd_addr == wr_addr);
    assign merged_wr = data_t'(be_merge(word_max_t'(mem[wr_idx]), word_max_t'(wr_data),
                                        be_max_t'(wr_be)));

    always_comb begin
        rd_next = '0;
        if (rd_in_range) rd_next = hit ? merged_wr : mem[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (clr_we)       mem[clr_idx] <= INIT_VALUE;
        else if (wr_fire) mem[wr_idx]  <= merged_wr;
    end

    data_t s1_data_q;
    logic  s1_valid_q, s1_coll_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_coll_q  <= 1'b0;
        end else begin
            s1_valid_q <= rd_fire;
            s1_coll_q  <= hit;
            if (rd_fire) s1_data_q <= rd_next;
        end
    end

`ifdef DPRAM_OUT_REG_EN
    data_t s2_data_q;
    logic  s2_valid_q, s2_coll_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_coll_q  <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_coll_q  <= s1_coll_q;
            if (s1_valid_q) s2_data_q <= s1_data_q;
        end
    end

    assign rd_data   = s2_data_q;
    assign rd_valid  = s2_valid_q;
    assign collision = s2_coll_q;
`else
    assign rd_data   = s1_data_q;
    assign rd_valid  = s1_valid_q;
    assign collision = s1_coll_q;
`endif

endmodule

// File: tb/tb_dual_port_sync_ram_param.sv
// Scoreboard bench: reads push expected words, a negedge monitor checks each rd_valid.
module tb_dual_port_sync_ram_param;

`ifdef DPRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en, rd_en;
    logic [4:0]  wr_addr, rd_addr;
    logic [15:0] wr_data, rd_data;
    logic [1:0]  wr_be;
    logic        rd_valid, init_busy, collision;

    dual_port_sync_ram_param #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (5),
        .DEPTH      (16),
        .INIT_VALUE (16'h00A5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .init_busy (init_busy),
        .collision (collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] data;
        logic        coll;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_exp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                mon_e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_read: no rd_valid by cycle %0d, expected data %h",
                         mon_e.due, mon_e.data);
            end
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got rd_data=%h with no read pending", rd_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rd_latency", cyc, mon_e.due);
                    check("rd_data", rd_data, mon_e.data);
                    check("collision", collision, mon_e.coll);
                end
            end
        end
    end

    task automatic cycle(input logic we, input int wa, input logic [15:0] wd, input logic [1:0] be,
                         input logic re, input int ra, input logic [15:0] ed, input logic ec);
        exp_t e;
        wr_en   = we;
        wr_addr = 5'(wa);
        wr_data = wd;
        wr_be   = be;
        rd_en   = re;
        rd_addr = 5'(ra);
        if (re) begin
            e.due    = cyc + LAT;
            e.data   = ed;
            e.coll   = ec;
            last_exp = ed;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic rd(input int ra, input logic [15:0] ed);
        cycle(1'b0, 0, 16'h0, 2'b00, 1'b1, ra, ed, 1'b0);
    endtask

    task automatic wr(input int wa, input logic [15:0] wd, input logic [1:0] be);
        cycle(1'b1, wa, wd, be, 1'b0, 0, 16'h0, 1'b0);
    endtask

    task automatic idle(input int n);
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_be = 2'b00;
        repeat (n) @(negedge clk);
    endtask

    // Counts negedge samples with init_busy high, starting at the release point.
    task automatic busy_count(output int n);
        n = 0;
        while (init_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; wr_be = 2'b00;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rd_data", rd_data, 16'h0);
        check("reset_rd_valid", rd_valid, 1'b0);
        check("reset_collision", collision, 1'b0);
        check("reset_init_busy", init_busy, 1'b1);

        // Requests held high for the whole clear must be ignored.
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 16'h7777; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 5'd3;
        reset = 1'b1;
        busy_count(n);
        check("init_busy_cycles", n, 16);
        idle(0);

        for (int i = 0; i < 16; i++) rd(i, 16'h00A5);
        for (int i = 0; i < 16; i++) wr(i, 16'(i + 1), 2'b11);
        for (int i = 0; i < 16; i++) rd(i, 16'(i + 1));

        wr(3, 16'h1234, 2'b11);
        wr(3, 16'hABCD, 2'b01);
        rd(3, 16'h12CD);
        wr(3, 16'h5600, 2'b10);
        rd(3, 16'h56CD);
        wr(3, 16'hFFFF, 2'b00);
        rd(3, 16'h56CD);

        wr(5, 16'h0000, 2'b11);
        cycle(1'b1, 5, 16'hBEEF, 2'b11, 1'b1, 5, 16'hBEEF, 1'b1);
        rd(5, 16'hBEEF);
        wr(5, 16'h0000, 2'b11);
        cycle(1'b1, 5, 16'hBEEF, 2'b00, 1'b1, 5, 16'h0000, 1'b0);
        cycle(1'b1, 5, 16'h3377, 2'b01, 1'b1, 5, 16'h0077, 1'b1);
        rd(5, 16'h0077);
        cycle(1'b1, 6, 16'h4242, 2'b11, 1'b1, 7, 16'h0008, 1'b0);

        cycle(1'b1, 20, 16'h9999, 2'b11, 1'b1, 20, 16'h0000, 1'b0);
        rd(31, 16'h0000);
        rd(4, 16'h0005);
        rd(6, 16'h4242);
        idle(LAT + 3);
        check("idle_rd_valid", rd_valid, 1'b0);
        check("hold_rd_data", rd_data, last_exp);

        for (int i = 0; i < 6; i++) rd(i, (i == 3) ? 16'h56CD : (i == 5) ? 16'h0077 : 16'(i + 1));
        #2;
        reset = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0;
        #1;
        check("midreset_rd_valid", rd_valid, 1'b0);
        check("midreset_rd_data", rd_data, 16'h0);
        check("midreset_collision", collision, 1'b0);
        check("midreset_init_busy", init_busy, 1'b1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        busy_count(n);
        check("reinit_busy_cycles", n, 16);

        rd(3, 16'h00A5);
        rd(5, 16'h00A5);
        rd(15, 16'h00A5);
        idle(LAT + 2);
        check("pending_reads", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
